// File: rtl/round_recorder.sv
// round_recorder -- records the per-round outcomes of one match.
//
// A match is opened by Start (from IDLE or DONE), then collects ROUNDS
// accepted round results. Each accepted result is packed into a 2-bit slot
// of Out_cr (slot k = bits [2k+1:2k]); unplayed slots stay 00. Done rises
// on the edge that commits the final round, together with the final Out_cr.
//
// Optional feature: define EARLY_DECIDE_EN to end the match as soon as the
// trailing player can no longer catch up with the leader (remaining slots
// are left at 00). With the macro undefined every match runs all ROUNDS.
//
// Reset is synchronous and active high; it wins over Start and Round_valid.

module round_recorder #(
  parameter int ROUNDS = 5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Round_valid,
  input  logic [1:0]            Round_result,
  output logic                  Ready,
  output logic [2*ROUNDS-1:0]   Out_cr,
  output logic [2:0]            Round_cnt,
  output logic                  Done
);

  localparam logic [2:0] ROUNDS_CNT = 3'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_next;

  // Per-player win tallies; a draw credits both players.
  logic [2:0] p1_w, p2_w;

  logic                start_take;
  logic                accept;
  logic [2:0]          cnt_inc;
  logic [2:0]          p1_inc, p2_inc;
  logic                last_round;
  logic                early_decide;
  logic [2*ROUNDS-1:0] out_cr_next;

  // Decode of the control events and the post-accept values they produce.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can leave it unassigned, which would otherwise infer a latch.
    start_take  = Start && (state != COLLECT);
    accept      = (state == COLLECT) && Round_valid && (Round_result != 2'b00);
    cnt_inc     = Round_cnt + 3'd1;
    p1_inc      = p1_w + {2'b00, Round_result[0]};
    p2_inc      = p2_w + {2'b00, Round_result[1]};
    last_round  = (cnt_inc == ROUNDS_CNT);
    out_cr_next = Out_cr;
    for (int i = 0; i < ROUNDS; i++) begin
      if (Round_cnt == 3'(i)) begin
        out_cr_next[2*i +: 2] = Round_result;
      end
    end
  end

`ifdef EARLY_DECIDE_EN
  logic [2:0] win_gap;
  logic [2:0] rounds_left;

  // Match is decided once the lead exceeds the rounds still to be played.
  always_comb begin
    win_gap      = (p1_inc >= p2_inc) ? (p1_inc - p2_inc) : (p2_inc - p1_inc);
    rounds_left  = ROUNDS_CNT - cnt_inc;
    early_decide = (win_gap > rounds_left);
  end
`else
  assign early_decide = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of block ordering.
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Start) state_next = COLLECT;
      COLLECT: if (accept && (last_round || early_decide)) state_next = DONE;
      DONE:    if (Start) state_next = COLLECT;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    Ready = (state == COLLECT);
    Done  = (state == DONE);
  end

  // Result vector, round counter and win tallies: clear on a new match,
  // commit one slot per accepted round, otherwise hold.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Out_cr    <= '0;
      Round_cnt <= '0;
      p1_w      <= '0;
      p2_w      <= '0;
    end else if (start_take) begin
      Out_cr    <= '0;
      Round_cnt <= '0;
      p1_w      <= '0;
      p2_w      <= '0;
    end else if (accept) begin
      Out_cr    <= out_cr_next;
      Round_cnt <= cnt_inc;
      p1_w      <= p1_inc;
      p2_w      <= p2_inc;
    end
  end

endmodule
